mel_accum_ctrl: RTL and testbench

// - Upstream sequencer and adder for the 23x44 mel band accumulator RAM (regmel port set).
// - Accepts weighted power-spectrum bins and performs a read-modify-write per bin:

---
 rtl/mel_accum_if.sv | 34 +++
 rtl/mel_accum_ctrl.sv | 84 ++++++++
 tb/tb_mel_accum_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mel_accum_if.sv
// mel_accum_if: bin input, mel band RAM port and dump output of the mel accumulator
interface mel_accum_if #(
   parameter int PW = 32,
   parameter int WW = 12,
   parameter int AW = 44
);
   logic          frame_start;
   logic          bin_valid;
   logic          bin_ready;
   logic [PW-1:0] bin_pow;
   logic [4:0]    bin_band;
   logic [WW-1:0] bin_weight;
   logic          bin_last;
   logic          regmel_wren;
   logic [4:0]    regmel_addr;
   logic [AW-1:0] addmel_out;
   logic [AW-1:0] regmel_out;
   logic          mel_valid;
   logic [4:0]    mel_band;
   logic [AW-1:0] mel_data;
   logic          busy;
   logic          sat_flag;
   logic          err_band;
   modport master (
      output frame_start, bin_valid, bin_pow, bin_band, bin_weight, bin_last, regmel_out,
      input  bin_ready, regmel_wren, regmel_addr, addmel_out, mel_valid, mel_band, mel_data,
             busy, sat_flag, err_band
   );
   modport slave (
      input  frame_start, bin_valid, bin_pow, bin_band, bin_weight, bin_last, regmel_out,
      output bin_ready, regmel_wren, regmel_addr, addmel_out, mel_valid, mel_band, mel_data,
             busy, sat_flag, err_band
   );
endinterface

// File: rtl/mel_accum_ctrl.sv
// mel_accum_ctrl: clear / saturating read-modify-write / dump sequencer for the mel band RAM
module mel_accum_ctrl #(
   parameter int NBANDS = 23,
   parameter int PW     = 32,
   parameter int WW     = 12,
   parameter int AW     = 44
) (
   input logic       clk,
   input logic       rst,
   mel_accum_if.slave m
);
   typedef enum logic [2:0] {IDLE, CLEAR, ACC, RD, WR, DUMP, DLAST} state_t;
   state_t        state;
   logic [4:0]    cnt, band_q;
   logic          last_q;
   logic [AW-1:0] prod_q;
   logic [AW:0]   sum;
   logic          cnt_end, bad_band;
   assign sum      = {1'b0, m.regmel_out} + {1'b0, prod_q};
   assign cnt_end  = cnt == 5'(NBANDS - 1);
   assign bad_band = m.bin_band >= 5'(NBANDS);
   always_comb begin
      m.bin_ready   = state == ACC && !m.frame_start;
      m.regmel_wren = state == CLEAR || state == WR;
      m.regmel_addr = (state == CLEAR || state == DUMP) ? cnt :
                      (state == RD || state == WR) ? band_q : '0;
      m.addmel_out  = state != WR ? '0 : sum[AW] ? '1 : sum[AW-1:0];
      m.mel_data    = m.mel_valid ? m.regmel_out : '0;
      m.busy        = state != IDLE;
   end
   // the read result of RD lands in regmel_out during WR, where the sum is formed
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         band_q      <= '0;
         last_q      <= 1'b0;
         prod_q      <= '0;
         m.mel_valid <= 1'b0;
         m.mel_band  <= '0;
         m.sat_flag  <= 1'b0;
         m.err_band  <= 1'b0;
      end else if (m.frame_start) begin
         state       <= CLEAR;
         cnt         <= '0;
         m.mel_valid <= 1'b0;
         m.sat_flag  <= 1'b0;
         m.err_band  <= 1'b0;
      end else begin
         m.mel_valid <= state == DUMP;
         m.mel_band  <= cnt;
         case (state)
            CLEAR: begin
               cnt <= cnt_end ? '0 : cnt + 5'd1;
               if (cnt_end) state <= ACC;
            end
            ACC: if (m.bin_valid) begin
               band_q <= m.bin_band;
               last_q <= m.bin_last;
               prod_q <= {{WW{1'b0}}, m.bin_pow} * {{PW{1'b0}}, m.bin_weight};
               if (bad_band) begin
                  m.err_band <= 1'b1;
                  if (m.bin_last) begin
                     state <= DUMP;
                     cnt   <= '0;
                  end
               end else state <= RD;
            end
            RD: state <= WR;
            WR: begin
               if (sum[AW]) m.sat_flag <= 1'b1;
               state <= last_q ? DUMP : ACC;
               cnt   <= '0;
            end
            DUMP: begin
               cnt <= cnt + 5'd1;
               if (cnt_end) state <= DLAST;
            end
            DLAST: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mel_accum_ctrl.sv
// tb_mel_accum_ctrl: directed and randomized frames against a band-total reference model
module tb_mel_accum_ctrl;
   localparam int NB = 23, PW = 32, WW = 12, AW = 44;
   logic clk = 1'b0;
   logic rst = 1'b1;
   mel_accum_if #(.PW(PW), .WW(WW), .AW(AW)) m ();
   mel_accum_ctrl #(.NBANDS(NB), .PW(PW), .WW(WW), .AW(AW)) dut (.clk(clk), .rst(rst), .m(m));
   always #5 clk = ~clk;

   logic [AW-1:0] ram [32];
   always @(posedge clk)
      if (m.regmel_wren) ram[m.regmel_addr] <= m.addmel_out;
      else m.regmel_out <= ram[m.regmel_addr];

   int n_tests = 0, n_fail = 0, cyc = 0, hs_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            dq_band [$];
   logic [AW-1:0] dq_data [$];
   int            dq_cyc  [$];
   always @(negedge clk)
      if (m.mel_valid) begin
         dq_band.push_back(int'(m.mel_band));
         dq_data.push_back(m.mel_data);
         dq_cyc.push_back(cyc);
      end

   logic [AW-1:0] mdl  [NB];
   logic [AW-1:0] dump [NB];
   bit m_sat, m_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame;
      int ok;
      m.frame_start = 1'b1;
      tick;
      m.frame_start = 1'b0;
      dq_band.delete(); dq_data.delete(); dq_cyc.delete();
      foreach (mdl[k]) mdl[k] = '0;
      m_sat = 0; m_err = 0;
      chk("fs_mel_valid", m.mel_valid, 0);
      chk("fs_sat", m.sat_flag, 0);
      chk("fs_err", m.err_band, 0);
      ok = 0;
      for (int k = 0; k < NB; k++) begin
         if (m.regmel_wren === 1'b1 && m.regmel_addr === 5'(k) && m.addmel_out === '0) ok++;
         tick;
      end
      chk("clear_cycles", ok, NB);
      chk("clear_ready", m.bin_ready, 1);
   endtask

   task automatic send_bin(input logic [31:0] pow, input logic [11:0] w, input logic [4:0] b,
                           input bit last, input bit abort);
      logic [AW:0]   sum;
      logic [AW-1:0] prod;
      int t;
      m.bin_valid = 1'b1; m.bin_pow = pow; m.bin_weight = w; m.bin_band = b; m.bin_last = last;
      t = 0;
      while (!m.bin_ready && t < 60) begin
         tick;
         t++;
      end
      if (!m.bin_ready) begin
         chk("ready_timeout", 0, 1);
         m.bin_valid = 1'b0;
         return;
      end
      tick;
      hs_cyc = cyc;
      m.bin_valid = 1'b0;
      if (abort) return;
      prod = AW'(pow) * AW'(w);
      if (b >= NB) begin
         m_err = 1;
         chk("bad_no_wren", m.regmel_wren, 0);
         chk("bad_err", m.err_band, 1);
         if (!last) chk("bad_hold_ready", m.bin_ready, 1);
      end else begin
         sum = {1'b0, mdl[b]} + {1'b0, prod};
         mdl[b] = sum[AW] ? '1 : sum[AW-1:0];
         if (sum[AW]) m_sat = 1;
         chk("rd_wren", m.regmel_wren, 0);
         chk("rd_addr", m.regmel_addr, b);
         chk("rd_ready", m.bin_ready, 0);
         tick;
         chk("wr_wren", m.regmel_wren, 1);
         chk("wr_addr", m.regmel_addr, b);
         chk("wr_data", m.addmel_out, mdl[b]);
         tick;
      end
   endtask

   task automatic finish_frame;
      int t, ok;
      t = 0;
      while (m.busy && t < 200) begin
         tick;
         t++;
      end
      chk("busy_fall", m.busy, 0);
      chk("dump_count", dq_data.size(), NB);
      foreach (dump[k]) dump[k] = '0;
      if (dq_data.size() == NB) begin
         ok = 0;
         for (int k = 0; k < NB; k++) begin
            dump[k] = dq_data[k];
            chk($sformatf("dump_b%0d", k), dq_data[k], mdl[k]);
            if (dq_band[k] == k) ok++;
         end
         chk("dump_bands", ok, NB);
         chk("dump_contig", dq_cyc[NB-1] - dq_cyc[0], NB - 1);
         chk("busy_after_dump", cyc - dq_cyc[NB-1], 1);
      end
      chk("sat_flag", m.sat_flag, m_sat);
      chk("err_band", m.err_band, m_err);
      chk("idle_ready", m.bin_ready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [4:0] b;
      logic [31:0] p;
      logic [11:0] w;
      int nb;
      foreach (ram[k]) ram[k] = '0;
      m.frame_start = 0; m.bin_valid = 0; m.bin_pow = '0; m.bin_band = '0;
      m.bin_weight = '0; m.bin_last = 0;
      repeat (3) tick;
      chk("rst_ready", m.bin_ready, 0);
      chk("rst_wren", m.regmel_wren, 0);
      chk("rst_addr", m.regmel_addr, 0);
      chk("rst_wdata", m.addmel_out, 0);
      chk("rst_mel_valid", m.mel_valid, 0);
      chk("rst_mel_band", m.mel_band, 0);
      chk("rst_mel_data", m.mel_data, 0);
      chk("rst_busy", m.busy, 0);
      chk("rst_sat", m.sat_flag, 0);
      chk("rst_err", m.err_band, 0);
      rst = 1'b0;
      tick;
      chk("idle_busy", m.busy, 0);

      start_frame;
      send_bin(32'd1000, 12'd2048, 5'd5, 1, 0);
      finish_frame;
      chk("t_single_b5", dump[5], 44'd2048000);
      chk("t_single_b4", dump[4], 0);

      start_frame;
      send_bin(32'd10, 12'd4, 5'd3, 0, 0);
      send_bin(32'd7, 12'd4095, 5'd3, 1, 0);
      finish_frame;
      chk("t_two_b3", dump[3], 44'd28705);

      start_frame;
      send_bin(32'hFFFFFFFF, 12'hFFF, 5'd0, 0, 0);
      send_bin(32'hFFFFFFFF, 12'hFFF, 5'd0, 1, 0);
      finish_frame;
      chk("t_sat_b0", dump[0], 44'hFFFFFFFFFFF);
      chk("t_sat_flag", m.sat_flag, 1);

      start_frame;
      send_bin(32'd1, 12'd1, 5'd23, 0, 0);
      send_bin(32'd1, 12'd1, 5'd23, 1, 0);
      finish_frame;
      if (dq_cyc.size() > 0) chk("bad_last_dump_now", dq_cyc[0], hs_cyc + 1);
      else chk("bad_last_dump_now", 0, 1);

      start_frame;
      send_bin(32'hFFFFFFFF, 12'hFFF, 5'd1, 0, 0);
      send_bin(32'hFFFFFFFF, 12'hFFF, 5'd1, 0, 0);
      send_bin(32'd3, 12'd3, 5'd30, 1, 0);
      repeat (5) tick;
      start_frame;
      send_bin(32'd100, 12'd100, 5'd7, 0, 0);
      send_bin(32'd5, 12'd5, 5'd9, 0, 1);
      start_frame;
      send_bin(32'd1, 12'd1, 5'd2, 1, 0);
      finish_frame;
      chk("abort_b7_cleared", dump[7], 0);
      chk("abort_b2", dump[2], 1);

      start_frame;
      send_bin(32'd9, 12'd9, 5'd4, 0, 0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midframe_rst_busy", m.busy, 0);
      chk("midframe_rst_ready", m.bin_ready, 0);

      for (int f = 0; f < 6; f++) begin
         start_frame;
         nb = $urandom_range(2, 14);
         for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) tick;
            b = ($urandom_range(0, 9) == 0) ? 5'(23 + $urandom_range(0, 8)) :
                ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 22));
            p = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            w = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            send_bin(p, w, b, i == nb - 1, 0);
         end
         finish_frame;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
